// File: rtl/mips_pkg.sv
// Shared fetch-stage types and defaults for the MIPS front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    localparam int          DEFAULT_WIDTH    = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // ISSUE: request on the bus; WAIT_RESP: one request in flight; HOLD: instruction presented
    typedef enum logic [1:0] {
        FS_ISSUE     = 2'd0,
        FS_WAIT_RESP = 2'd1,
        FS_HOLD      = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_perf_counter.sv
// Fetch performance counters: instructions advanced and stalled-hold cycles.
// Latency: counts visible one cycle after the qualifying event.
// Backpressure: none; both counters wrap at 2^32.
module fetch_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_fetch_adv,
    input  logic        i_stall_cyc,
    output logic [31:0] o_perf_fetched,
    output logic [31:0] o_perf_stalls
);

    logic [31:0] r_fetched;
    logic [31:0] r_stalls;

    // Free-running event counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetched <= '0;
            r_stalls  <= '0;
        end else begin
            if (i_fetch_adv) r_fetched <= r_fetched + 32'd1;
            if (i_stall_cyc) r_stalls  <= r_stalls + 32'd1;
        end
    end

    assign o_perf_fetched = r_fetched;
    assign o_perf_stalls  = r_stalls;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, presents instr/pc+4 to the F/D register.
// Latency: accept edge + response edge, so valid_f rises at the earliest two cycles after acceptance.
// Backpressure: stall_f holds the presented instruction and pc; redirect overrides everything.
// Optional perf counters built when FETCH_PERF_CNT_EN is defined; otherwise they read 0.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_f,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr_f,
    output logic [WIDTH-1:0] pc_plus4_f,
    output logic             valid_f,
    output logic             fd_en,
    output logic             fd_clr,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_stalls
);

    fetch_state_e     r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_kill;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_pc_plus4;
    logic             r_valid;

    logic [WIDTH-1:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + WIDTH'(4);

    // A redirect withdraws an unaccepted request in the same cycle, so the memory
    // never sees a fetch for a path that is already dead.
    assign imem_req   = (r_state == FS_ISSUE) && !redirect && !rst;
    assign imem_addr  = r_pc;
    assign instr_f    = r_instr;
    assign pc_plus4_f = r_pc_plus4;
    assign valid_f    = r_valid;
    assign fd_en      = r_valid && !stall_f && !redirect && !rst;
    assign fd_clr     = redirect && !rst;

    // Fetch FSM: redirect beats stall and every transition; kill marks an in-flight
    // response that belongs to a squashed path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FS_ISSUE;
            r_pc       <= RESET_PC;
            r_kill     <= 1'b0;
            r_instr    <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (redirect) begin
            r_pc    <= redirect_pc;
            r_valid <= 1'b0;
            if (r_state == FS_WAIT_RESP && !imem_rvalid) begin
                r_kill <= 1'b1;
            end else begin
                r_kill  <= 1'b0;
                r_state <= FS_ISSUE;
            end
        end else begin
            case (r_state)
                FS_ISSUE: begin
                    if (imem_ready) r_state <= FS_WAIT_RESP;
                end
                FS_WAIT_RESP: begin
                    if (imem_rvalid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= FS_ISSUE;
                        end else begin
                            r_instr    <= imem_rdata;
                            r_pc_plus4 <= w_pc_plus4;
                            r_valid    <= 1'b1;
                            r_state    <= FS_HOLD;
                        end
                    end
                end
                FS_HOLD: begin
                    if (!stall_f) begin
                        r_pc    <= w_pc_plus4;
                        r_valid <= 1'b0;
                        r_state <= FS_ISSUE;
                    end
                end
                default: begin
                    r_state <= FS_ISSUE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic w_fetch_adv;
    logic w_stall_cyc;

    assign w_fetch_adv = (r_state == FS_HOLD) && !stall_f && !redirect;
    assign w_stall_cyc = (r_state == FS_HOLD) && stall_f && !redirect;

    fetch_perf_counter u_perf (
        .clk            (clk),
        .rst            (rst),
        .i_fetch_adv    (w_fetch_adv),
        .i_stall_cyc    (w_stall_cyc),
        .o_perf_fetched (perf_fetched),
        .o_perf_stalls  (perf_stalls)
    );
`else
    assign perf_fetched = 32'd0;
    assign perf_stalls  = 32'd0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: WIDTH, 32, data/address width.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 stall_f  input  1  hold current instruction and PC.
REQ-006 redirect  input  1  branch/jump taken; overrides fetch.
REQ-007 redirect_pc  input  WIDTH  target address, sampled when redirect=1.
REQ-008 imem_req  output  1  fetch request valid.
REQ-009 imem_addr  output  WIDTH  fetch address, equals pc while imem_req=1.
REQ-010 imem_ready  input  1  memory accepts request when imem_req&imem_ready.
REQ-011 imem_rvalid  input  1  read data valid, one pulse per accepted request.
REQ-012 imem_rdata  input  WIDTH  instruction word.
REQ-013 instr_f  output  WIDTH  fetched instruction to the fetch/decode register.
REQ-014 pc_plus4_f  output  WIDTH  address of instr_f plus 4.
REQ-015 valid_f  output  1  instr_f/pc_plus4_f hold a live instruction.
REQ-016 fd_en  output  1  fetch/decode register enable = valid_f & ~stall_f & ~redirect.
REQ-017 fd_clr  output  1  fetch/decode register clear = redirect.
REQ-018 perf_fetched, perf_stalls  output  32 each  performance counters (see Configuration).

Function
REQ-019 FSM states ISSUE, WAIT_RESP, HOLD; at most one request outstanding.
REQ-020 ISSUE: imem_req=1, imem_addr=pc, valid_f=0; on imem_ready -> WAIT_RESP.
REQ-021 WAIT_RESP: imem_req=0; on imem_rvalid with kill=0, capture imem_rdata into instr buffer and pc+4 into pc_plus4 buffer; -> HOLD same edge.
REQ-022 HOLD: valid_f=1; if stall_f=0, pc <= pc+4 and -> ISSUE next edge; if stall_f=1, remain, outputs unchanged.
REQ-023 Fetch latency: first valid_f no earlier than 2 cycles after imem_req accepted (accept edge, rvalid edge).
REQ-024 redirect has priority over stall_f and all FSM transitions.
REQ-025 redirect in ISSUE or HOLD: pc <= redirect_pc, valid_f <= 0, -> ISSUE; request not yet accepted is withdrawn.
REQ-026 redirect in WAIT_RESP without rvalid: pc <= redirect_pc, kill <= 1, remain WAIT_RESP; response arriving with kill=1 is discarded, kill <= 0, -> ISSUE.
REQ-027 redirect coincident with imem_rvalid: response discarded, pc <= redirect_pc, -> ISSUE.
REQ-028 pc arithmetic modulo 2^WIDTH; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-029 imem_rvalid outside WAIT_RESP ignored.

Reset
REQ-030 rst=1 at a clock edge: pc=RESET_PC, state=ISSUE, kill=0, instr/pc_plus4 buffers=0, valid_f=0, counters=0.
REQ-031 During rst=1: imem_req=0, fd_en=0, fd_clr=0; first request issues in the cycle after rst deasserts.
REQ-032 rst asserted in WAIT_RESP: in-flight response arriving after reset deassertion is ignored (state=ISSUE).

Configuration
REQ-033 Macro FETCH_PERF_CNT_EN defined: perf_fetched increments on each HOLD->ISSUE advance; perf_stalls increments each cycle in HOLD with stall_f=1; both wrap at 2^32.
REQ-034 Macro undefined: counters not built, perf_fetched=perf_stalls=0 constantly.

Structure
REQ-035 Shared package mips_pkg holds fetch-state enum, RESET_PC default, WIDTH default.
REQ-036 Counters live in sub-module fetch_perf_counter, instantiated only under FETCH_PERF_CNT_EN.

Verification
REQ-037 Reset then imem_ready=1, rvalid 1 cycle later, rdata=32'h2008_0005 -> imem_addr=0, instr_f=32'h2008_0005, pc_plus4_f=4, valid_f=1, next imem_addr=4.
REQ-038 stall_f=1 for 3 cycles in HOLD -> valid_f, instr_f constant, fd_en=0, no new imem_req; perf_stalls=3 with macro.
REQ-039 redirect=1, redirect_pc=32'h0000_0040 in WAIT_RESP, rvalid next cycle -> data discarded, valid_f=0, fd_clr=1 one cycle, next imem_addr=32'h40.
REQ-040 redirect and imem_rvalid same cycle, redirect_pc=32'h100 -> no valid_f, next imem_addr=32'h100.
REQ-041 pc=32'hFFFF_FFFC fetched, stall_f=0 -> pc_plus4_f=0, next imem_addr=0.
REQ-042 rst=1 in WAIT_RESP, rvalid after deassert -> ignored, imem_addr=RESET_PC, valid_f=0.
